// File: rtl/io_mmio_ctrl_pkg.sv
// rtl/io_mmio_ctrl_pkg.sv - register offsets for the MMIO controller
// Offsets are matched against addr[7:0]; everything else in the window is unmapped.
package io_mmio_ctrl_pkg;
    localparam logic [7:0] OFF_STATUS   = 8'h00;
    localparam logic [7:0] OFF_RX_DATA  = 8'h04;
    localparam logic [7:0] OFF_TX_DATA  = 8'h08;
    localparam logic [7:0] OFF_CYC_CNT  = 8'h10;
    localparam logic [7:0] OFF_INST_CNT = 8'h14;
    localparam logic [7:0] OFF_CNT_RST  = 8'h18;
endpackage

// File: rtl/io_fifo.sv
// rtl/io_fifo.sv - first-word fall-through FIFO with count-based full/empty
// Ports: clk, rst (sync, active-high), push/din, pop/dout, full, empty.
// A push while full and a pop while empty are ignored; the full check uses the
// state before the edge, so a push on a full FIFO is dropped even if it also pops.
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - CNT_ONE;
            end
        end
    end
endmodule

// File: rtl/io_mmio_ctrl.sv
// rtl/io_mmio_ctrl.sv - MMIO bridge between CPU load/store and the UART, plus counters
// Ports: clk, rst (sync, active-high); addr/wdata/we/re/rdata CPU side (rdata one
// cycle after re); inst_retired pulse; uart_rx_data_out* from the receiver;
// uart_tx_data_in* to the transmitter.
module io_mmio_ctrl
    import io_mmio_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    input  logic        inst_retired,
    input  logic [7:0]  uart_rx_data_out,
    input  logic        uart_rx_data_out_valid,
    output logic        uart_rx_data_out_ready,
    output logic [7:0]  uart_tx_data_in,
    output logic        uart_tx_data_in_valid,
    input  logic        uart_tx_data_in_ready
);
    logic [7:0]  off;
    logic [7:0]  rx_dout;
    logic        rx_full;
    logic        rx_empty;
    logic        tx_full;
    logic        tx_empty;
    logic [31:0] cyc_cnt;
    logic [31:0] inst_cnt;
    logic [31:0] rd_next;
    logic        cnt_clr;
    logic        unused_bits;

    assign off         = addr[7:0];
    assign cnt_clr     = we && (off == OFF_CNT_RST);
    assign unused_bits = ^{addr[31:8], wdata[31:8]};

    // Push/pop strobes are qualified by full/empty inside the FIFO.
    io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (uart_rx_data_out_valid),
        .din   (uart_rx_data_out),
        .pop   (re && (off == OFF_RX_DATA)),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (we && (off == OFF_TX_DATA)),
        .din   (wdata[7:0]),
        .pop   (uart_tx_data_in_ready),
        .dout  (uart_tx_data_in),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign uart_rx_data_out_ready = !rx_full;
    assign uart_tx_data_in_valid  = !tx_empty;

    always_comb begin
        rd_next = '0;
        case (off)
            OFF_STATUS:   rd_next = {30'b0, !rx_empty, !tx_full};
            OFF_RX_DATA:  rd_next = rx_empty ? 32'h0 : {24'b0, rx_dout};
            OFF_CYC_CNT:  rd_next = cyc_cnt;
            OFF_INST_CNT: rd_next = inst_cnt;
            default:      rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rd_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cyc_cnt  <= '0;
            inst_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (inst_retired) begin
                inst_cnt <= inst_cnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_io_mmio_ctrl.sv
// tb/tb_io_mmio_ctrl.sv - self-checking bench for io_mmio_ctrl
module tb_io_mmio_ctrl;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] rdata;
    logic        inst_retired = 1'b0;
    logic [7:0]  uart_rx_data_out = '0;
    logic        uart_rx_data_out_valid = 1'b0;
    logic        uart_rx_data_out_ready;
    logic [7:0]  uart_tx_data_in;
    logic        uart_tx_data_in_valid;
    logic        uart_tx_data_in_ready = 1'b1;

    io_mmio_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .addr                   (addr),
        .wdata                  (wdata),
        .we                     (we),
        .re                     (re),
        .rdata                  (rdata),
        .inst_retired           (inst_retired),
        .uart_rx_data_out       (uart_rx_data_out),
        .uart_rx_data_out_valid (uart_rx_data_out_valid),
        .uart_rx_data_out_ready (uart_rx_data_out_ready),
        .uart_tx_data_in        (uart_tx_data_in),
        .uart_tx_data_in_valid  (uart_tx_data_in_valid),
        .uart_tx_data_in_ready  (uart_tx_data_in_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the two FIFOs as queues, counters as plain integers.
    logic [7:0]  rx_src[$];
    logic [7:0]  m_rxq[$];
    logic [7:0]  m_txq[$];
    logic [7:0]  m_tx_sent[$];
    logic [31:0] m_cyc = '0;
    logic [31:0] m_ins = '0;
    logic [31:0] m_rdata = '0;
    bit          live = 0;
    logic [7:0]  m_off;
    bit          m_rx_pop, m_rx_push, m_tx_pop, m_tx_push, m_clr;

    always @(posedge clk) begin
        if (rst) begin
            m_rxq.delete();
            m_txq.delete();
            m_cyc   = '0;
            m_ins   = '0;
            m_rdata = '0;
            live    = 1;
        end else begin
            m_off = addr[7:0];
            if (re) begin
                case (m_off)
                    8'h00:   m_rdata = {30'b0, m_rxq.size() != 0, m_txq.size() != DEPTH};
                    8'h04:   m_rdata = (m_rxq.size() != 0) ? {24'b0, m_rxq[0]} : 32'h0;
                    8'h10:   m_rdata = m_cyc;
                    8'h14:   m_rdata = m_ins;
                    default: m_rdata = 32'h0;
                endcase
            end
            m_rx_pop  = re && m_off == 8'h04 && m_rxq.size() > 0;
            m_rx_push = uart_rx_data_out_valid && m_rxq.size() < DEPTH;
            m_tx_pop  = m_txq.size() > 0 && uart_tx_data_in_ready;
            m_tx_push = we && m_off == 8'h08 && m_txq.size() < DEPTH;
            m_clr     = we && m_off == 8'h18;
            if (m_rx_pop) void'(m_rxq.pop_front());
            if (m_rx_push) begin
                m_rxq.push_back(uart_rx_data_out);
                void'(rx_src.pop_front());
            end
            if (m_tx_pop) m_tx_sent.push_back(m_txq.pop_front());
            if (m_tx_push) m_txq.push_back(wdata[7:0]);
            m_cyc = m_clr ? 32'h0 : m_cyc + 32'd1;
            m_ins = m_clr ? 32'h0 : m_ins + {31'b0, inst_retired};
        end
    end

    // Receiver: presents the head of rx_src until the model records acceptance.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            uart_rx_data_out_valid = (rx_src.size() > 0);
            uart_rx_data_out       = (rx_src.size() > 0) ? rx_src[0] : 8'h00;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("rdata", rdata, m_rdata);
            chk("rx_ready", {31'b0, uart_rx_data_out_ready}, {31'b0, m_rxq.size() < DEPTH});
            chk("tx_valid", {31'b0, uart_tx_data_in_valid}, {31'b0, m_txq.size() > 0});
            if (m_txq.size() > 0)
                chk("tx_data", {24'b0, uart_tx_data_in}, {24'b0, m_txq[0]});
        end
    end

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        re = 1'b1;
        addr = a;
        @(posedge clk);
        #1;
        re = 1'b0;
        v = rdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1;
        addr = a;
        wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] v, v2;
    logic [7:0]  r_lo;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        // 1: reset state, status, cycle counter spacing
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_tx_valid", {31'b0, uart_tx_data_in_valid}, 32'h0);
        chk("reset_rx_ready", {31'b0, uart_rx_data_out_ready}, 32'h1);
        rd(32'h8000_0000, v);
        chk("status_after_reset", v, 32'h1);
        rd(32'h8000_0010, v);
        idle(4);
        rd(32'h8000_0010, v2);
        chk("cycle_delta", v2 - v, 32'd5);

        // 2: two received bytes, then empty read
        rx_src.push_back(8'h41);
        rx_src.push_back(8'h42);
        idle(5);
        rd(32'h8000_0004, v);
        chk("rx_first", v, 32'h41);
        rd(32'h8000_0004, v);
        chk("rx_second", v, 32'h42);
        rd(32'h8000_0000, v);
        chk("status_rx_drained", v, 32'h1);
        rd(32'h8000_0004, v);
        chk("rx_empty_read", v, 32'h0);

        // 3: overfill RX by one; the ninth waits at the receiver
        for (int i = 0; i < 9; i++) rx_src.push_back(8'h50 + 8'(i));
        idle(14);
        chk("rx_ready_full", {31'b0, uart_rx_data_out_ready}, 32'h0);
        rd(32'h8000_0000, v);
        chk("status_rx_full", v, 32'h3);
        for (int i = 0; i < 9; i++) begin
            rd(32'h8000_0004, v);
            chk($sformatf("rx_fill_%0d", i), v, 32'h50 + i);
        end

        // 4: overfill TX while the transmitter stalls
        uart_tx_data_in_ready = 1'b0;
        for (int i = 0; i < 10; i++) wr(32'h8000_0008, 32'h30 + i);
        rd(32'h8000_0000, v);
        chk("status_tx_full", v, 32'h0);
        m_tx_sent.delete();
        uart_tx_data_in_ready = 1'b1;
        idle(12);
        chk("tx_sent_count", m_tx_sent.size(), 32'd8);
        for (int i = 0; i < 8 && i < m_tx_sent.size(); i++)
            chk($sformatf("tx_sent_%0d", i), {24'b0, m_tx_sent[i]}, 32'h30 + i);
        chk("tx_drained_valid", {31'b0, uart_tx_data_in_valid}, 32'h0);

        // 5: counters, clear, wrap
        wr(32'h8000_0018, 32'h0);
        for (int i = 0; i < 3; i++) begin
            inst_retired = 1'b1;
            idle(1);
            inst_retired = 1'b0;
            idle(1);
        end
        rd(32'h8000_0014, v);
        chk("instret_3", v, 32'd3);
        wr(32'h8000_0018, 32'h0);
        rd(32'h8000_0010, v);
        chk("cyc_after_clear", v, 32'd0);
        rd(32'h8000_0014, v);
        chk("instret_after_clear", v, 32'd0);
        force dut.cyc_cnt = 32'hFFFF_FFFE;
        m_cyc = 32'hFFFF_FFFE;
        #1;
        release dut.cyc_cnt;
        rd(32'h8000_0010, v);
        chk("cyc_pre_wrap", v, 32'hFFFF_FFFE);
        rd(32'h8000_0010, v);
        chk("cyc_max", v, 32'hFFFF_FFFF);
        rd(32'h8000_0010, v);
        chk("cyc_wrapped", v, 32'h0);

        // 6: reset with both FIFOs holding data
        uart_tx_data_in_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(32'h8000_0008, 32'hA0 + i);
        for (int i = 0; i < 4; i++) rx_src.push_back(8'hB0 + 8'(i));
        idle(8);
        rd(32'h8000_0010, v);
        rst = 1'b1;
        idle(1);
        chk("rst_tx_valid", {31'b0, uart_tx_data_in_valid}, 32'h0);
        chk("rst_rx_ready", {31'b0, uart_rx_data_out_ready}, 32'h1);
        chk("rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        rd(32'h8000_0000, v);
        chk("rst_status", v, 32'h1);
        uart_tx_data_in_ready = 1'b1;

        // Randomized traffic checked every cycle by the model
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 6))
                0: r_lo = 8'h00;
                1: r_lo = 8'h04;
                2: r_lo = 8'h08;
                3: r_lo = 8'h10;
                4: r_lo = 8'h14;
                5: r_lo = ($urandom_range(0, 7) == 0) ? 8'h18 : 8'h08;
                default: r_lo = 8'($urandom);
            endcase
            addr = {24'($urandom), r_lo};
            re = 1'($urandom_range(0, 1));
            we = ($urandom_range(0, 2) == 0);
            wdata = $urandom;
            inst_retired = 1'($urandom_range(0, 1));
            uart_tx_data_in_ready = ($urandom_range(0, 3) != 0);
            if (rx_src.size() < 2 && $urandom_range(0, 2) == 0)
                rx_src.push_back(8'($urandom));
            idle(1);
        end
        re = 1'b0;
        we = 1'b0;
        inst_retired = 1'b0;
        uart_tx_data_in_ready = 1'b1;
        idle(20);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
